codificador_instrucao: RTL

CODIFICADOR_INSTRUCAO -- requirements
Module: codificador_instrucao

---
 rtl/codificador_pkg.sv | 38 +++
 rtl/codificador_instrucao_if.sv | 32 +++
 rtl/fifo_sincrona.sv | 46 ++++
 rtl/codificador_instrucao.sv | 91 +++++++++
 4 files changed

// File: rtl/codificador_pkg.sv
// Shared MIPS encoding constants: instruction classes, ALU control codes,
// primary opcodes and R-type funct fields.
package codificador_pkg;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LW   = 3'd1,
        CLS_SW   = 3'd2,
        CLS_BEQ  = 3'd3,
        CLS_ADDI = 3'd4,
        CLS_J    = 3'd5
    } classe_t;

    // ULAControl codes accepted for R-type instructions; 100 and 101 are unused.
    typedef enum logic [2:0] {
        ULA_AND = 3'b000,
        ULA_OR  = 3'b001,
        ULA_ADD = 3'b010,
        ULA_NOR = 3'b011,
        ULA_SUB = 3'b110,
        ULA_SLT = 3'b111
    } ula_op_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/codificador_instrucao_if.sv
// Request and instruction-memory bus of the instruction encoder.
// master = requester/memory side, slave = encoder.
interface codificador_instrucao_if #(
    parameter int AW = 8
) ();
    logic          Clear;
    logic          InValid;
    logic          InReady;
    logic [2:0]    Classe;
    logic [2:0]    ULAOp;
    logic [4:0]    Rs;
    logic [4:0]    Rt;
    logic [4:0]    Rd;
    logic [15:0]   Imm;
    logic [25:0]   Target;
    logic          MemWrite;
    logic          MemReady;
    logic [AW-1:0] Addr;
    logic [31:0]   Instr;
    logic          Err;
    logic [7:0]    ErrCount;

    modport master (
        output Clear, InValid, Classe, ULAOp, Rs, Rt, Rd, Imm, Target, MemReady,
        input  InReady, MemWrite, Addr, Instr, Err, ErrCount
    );

    modport slave (
        input  Clear, InValid, Classe, ULAOp, Rs, Rt, Rd, Imm, Target, MemReady,
        output InReady, MemWrite, Addr, Instr, Err, ErrCount
    );
endinterface

// File: rtl/fifo_sincrona.sv
// Synchronous FIFO with full/empty flags and synchronous clear.
// Pointers carry one extra wrap bit to tell full from empty (DEPTH >= 2).
module fifo_sincrona #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end
endmodule

// File: rtl/codificador_instrucao.sv
// Encodes instruction requests into 32-bit MIPS words, queues them and writes
// them to consecutive instruction-memory addresses; rejects invalid requests.
module codificador_instrucao
    import codificador_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    codificador_instrucao_if.slave bus
);
    logic [31:0]   enc_word;
    logic          enc_ok;
    logic [5:0]    funct;
    logic          accept;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_dout;
    logic          mem_fire;
    logic [AW-1:0] addr_q;
    logic          err_q;
    logic [7:0]    err_count_q;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        enc_ok   = 1'b1;
        enc_word = '0;
        funct    = '0;
        case (bus.Classe)
            CLS_R: begin
                case (bus.ULAOp)
                    ULA_ADD: funct = FN_ADD;
                    ULA_SUB: funct = FN_SUB;
                    ULA_AND: funct = FN_AND;
                    ULA_OR:  funct = FN_OR;
                    ULA_NOR: funct = FN_NOR;
                    ULA_SLT: funct = FN_SLT;
                    default: enc_ok = 1'b0;
                endcase
                enc_word = {OP_R, bus.Rs, bus.Rt, bus.Rd, 5'b00000, funct};
            end
            CLS_LW:   enc_word = {OP_LW,   bus.Rs, bus.Rt, bus.Imm};
            CLS_SW:   enc_word = {OP_SW,   bus.Rs, bus.Rt, bus.Imm};
            CLS_BEQ:  enc_word = {OP_BEQ,  bus.Rs, bus.Rt, bus.Imm};
            CLS_ADDI: enc_word = {OP_ADDI, bus.Rs, bus.Rt, bus.Imm};
            CLS_J:    enc_word = {OP_J,    bus.Target};
            default:  enc_ok = 1'b0;
        endcase
    end

    // A full FIFO refuses requests even if the head drains in the same cycle.
    assign accept   = bus.InValid && !fifo_full;
    assign mem_fire = !fifo_empty && bus.MemReady;

    fifo_sincrona #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.Clear),
        .push  (accept && enc_ok),
        .pop   (mem_fire),
        .din   (enc_word),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (bus.Clear)    addr_q <= '0;
            else if (mem_fire) addr_q <= addr_q + 1'b1;
            err_q <= accept && !enc_ok;
            if (accept && !enc_ok && err_count_q != 8'hFF)
                err_count_q <= err_count_q + 8'd1;
        end
    end

    assign bus.InReady  = !fifo_full;
    assign bus.MemWrite = !fifo_empty;
    assign bus.Instr    = fifo_empty ? 32'h0 : fifo_dout;
    assign bus.Addr     = addr_q;
    assign bus.Err      = err_q;
    assign bus.ErrCount = err_count_q;
endmodule
